dcache_snoop_responder: RTL

- Cache-side responder for the coherence bus in each L1 data cache of the dual-core system; one instance per core.
- Answers snoop requests from the memory controller against the local tag/state array (MSI).
- Drives ccwrite. Flushes Modified blocks word-by-word over the shared dstore/daddr/dWEN path, which supplies the requester and RAM together.
- Downgrades or invalidates local lines, and clears the LL/SC link register on a remote invalidation.

---
 rtl/dcache_snoop_responder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/dcache_snoop_responder.sv
// dcache_snoop_responder
//   Cache-side coherence responder for one L1 data cache (MSI). It looks up
//   the snooped address in the local tag/state array and answers the memory
//   controller. A Modified hit raises ccwrite and flushes the block one word
//   at a time over daddr/dstore/dWEN. After the flush the line is downgraded
//   to S, or invalidated if the requester intends to write. A Shared hit
//   with ccinv is invalidated in place. A matching LL link is cleared when a
//   remote requester invalidates the block.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   ccwait, ccinv        snoop request / requester-will-write
//   ccsnoopaddr          snooped address
//   dwait                controller wait; low for one cycle = word accepted
//   snp_idx, snp_tag     combinational lookup key into the tag/state array
//   way_hit/state/data   per-way lookup results for snp_idx/snp_tag
//   link_valid/addr      LL/SC link register contents
//   ccwrite              this cache supplies the snooped block
//   daddr, dstore, dWEN  flush word path
//   upd_en/idx/way/state one-cycle state-array write
//   snoop_busy           local cache FSM must stay off the bus and arrays
//   link_clr             one-cycle link register clear
module dcache_snoop_responder #(
  parameter int unsigned SETS = 8,
  parameter int unsigned WAYS = 2,
  localparam int unsigned IDX_W = $clog2(SETS),
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int unsigned TAG_W = 32 - IDX_W - 3
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                ccwait,
  input  logic                ccinv,
  input  logic [31:0]         ccsnoopaddr,
  input  logic                dwait,
  output logic [IDX_W-1:0]    snp_idx,
  output logic [TAG_W-1:0]    snp_tag,
  input  logic [WAYS-1:0]     way_hit,
  input  logic [2*WAYS-1:0]   way_state,
  input  logic [64*WAYS-1:0]  way_data,
  input  logic                link_valid,
  input  logic [31:0]         link_addr,
  output logic                ccwrite,
  output logic [31:0]         daddr,
  output logic [31:0]         dstore,
  output logic                dWEN,
  output logic                upd_en,
  output logic [IDX_W-1:0]    upd_idx,
  output logic [WAY_W-1:0]    upd_way,
  output logic [1:0]          upd_state,
  output logic                snoop_busy,
  output logic                link_clr
);

  localparam logic [1:0] MsiI = 2'b00;
  localparam logic [1:0] MsiS = 2'b01;
  localparam logic [1:0] MsiM = 2'b10;

  typedef enum logic [1:0] {StIdle, StFlush0, StFlush1} state_e;

  state_e             r_state, w_state_next;
  logic               r_serviced, w_serviced_next;
  logic [IDX_W-1:0]   r_idx;
  logic [TAG_W-1:0]   r_tag;
  logic [WAY_W-1:0]   r_way;
  logic [63:0]        r_data;
  logic               r_inv;

  logic [WAY_W-1:0]   w_sel_way;
  logic [1:0]         w_sel_state;
  logic [63:0]        w_sel_data;
  logic               w_hit;
  logic               w_m_hit;
  logic               w_s_hit;
  logic               w_snoop;
  logic               w_link_match;

  assign snp_idx = ccsnoopaddr[IDX_W+2:3];
  assign snp_tag = ccsnoopaddr[31:IDX_W+3];

  // Lowest-indexed valid hit wins; state 11 is treated as invalid.
  always_comb begin
    w_sel_way   = '0;
    w_sel_state = MsiI;
    w_sel_data  = '0;
    w_hit       = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (way_hit[i] && (way_state[2*i +: 2] == MsiS || way_state[2*i +: 2] == MsiM)) begin
        w_sel_way   = WAY_W'(i);
        w_sel_state = way_state[2*i +: 2];
        w_sel_data  = way_data[64*i +: 64];
        w_hit       = 1'b1;
      end
    end
  end

  assign w_m_hit      = w_hit & (w_sel_state == MsiM);
  assign w_s_hit      = w_hit & (w_sel_state == MsiS);
  // A new, not yet answered snoop; nRST gating keeps outputs 0 during reset.
  assign w_snoop      = ccwait & nRST & ~r_serviced;
  assign w_link_match = link_valid & (link_addr[31:3] == ccsnoopaddr[31:3]);

  // State register and latched snoop context
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= StIdle;
      r_serviced <= 1'b0;
      r_idx      <= '0;
      r_tag      <= '0;
      r_way      <= '0;
      r_data     <= '0;
      r_inv      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_serviced <= w_serviced_next;
      if (r_state == StIdle && w_snoop && w_m_hit) begin
        r_idx  <= snp_idx;
        r_tag  <= snp_tag;
        r_way  <= w_sel_way;
        r_data <= w_sel_data;
        r_inv  <= ccinv;
      end
    end
  end

  // Next state
  always_comb begin
    w_state_next    = r_state;
    w_serviced_next = r_serviced;
    unique case (r_state)
      StIdle: begin
        if (w_snoop && w_m_hit) begin
          w_state_next = StFlush0;
        end else if (w_snoop) begin
          // Miss and S hits complete in the snoop cycle itself.
          w_serviced_next = 1'b1;
        end
      end
      StFlush0: begin
        if (!ccwait)     w_state_next = StIdle;
        else if (!dwait) w_state_next = StFlush1;
      end
      StFlush1: begin
        if (!ccwait) begin
          w_state_next = StIdle;
        end else if (!dwait) begin
          w_state_next    = StIdle;
          w_serviced_next = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
    if (!ccwait) w_serviced_next = 1'b0;
  end

  // Outputs
  always_comb begin
    ccwrite    = 1'b0;
    daddr      = '0;
    dstore     = '0;
    dWEN       = 1'b0;
    upd_en     = 1'b0;
    upd_idx    = '0;
    upd_way    = '0;
    upd_state  = MsiI;
    snoop_busy = 1'b0;
    link_clr   = 1'b0;
    unique case (r_state)
      StIdle: begin
        snoop_busy = ccwait & nRST;
        ccwrite    = w_snoop & w_m_hit;
        link_clr   = w_snoop & ccinv & w_link_match;
        if (w_snoop && w_s_hit && ccinv) begin
          upd_en    = 1'b1;
          upd_idx   = snp_idx;
          upd_way   = w_sel_way;
          upd_state = MsiI;
        end
      end
      StFlush0: begin
        ccwrite    = 1'b1;
        dWEN       = 1'b1;
        snoop_busy = 1'b1;
        daddr      = {r_tag, r_idx, 1'b0, 2'b00};
        dstore     = r_data[31:0];
      end
      StFlush1: begin
        ccwrite    = 1'b1;
        dWEN       = 1'b1;
        snoop_busy = 1'b1;
        daddr      = {r_tag, r_idx, 1'b1, 2'b00};
        dstore     = r_data[63:32];
        if (ccwait && !dwait) begin
          upd_en    = 1'b1;
          upd_idx   = r_idx;
          upd_way   = r_way;
          upd_state = r_inv ? MsiI : MsiS;
        end
      end
      default: ;
    endcase
  end

endmodule
